ecc_decoder_pipe: RTL and testbench
===================================

// Module: ecc_decoder_pipe
// PURPOSE
//  SECDED decoder directly downstream of Encoder. Accepts an LSB-aligned 8/16/32-bit codeword
//  (the Encoder's Enc_Out format), computes the syndrome with the Encoder's parity equations,
//  corrects single errors, flags double errors and emits LSB-aligned data plus error class.
//  3-stage pipeline, valid/ready both sides, saturating error-statistics counters.
// PARAMETERS
//  AMBA_WORD  32  codeword/data bus width; fixed, never overridden.
//  CNT_W      16  width of the correction/uncorrectable statistics counters.
// PORTS
//  clk            in   1          single clock, rising edge
//  rst            in   1          synchronous, active-low reset
//  in_valid       in   1          DATA_IN/CODEWORD_WIDTH valid
//  in_ready       out  1          stage 0 can accept
//  DATA_IN        in   AMBA_WORD  received codeword, LSB-aligned, upper bits ignored
//  CODEWORD_WIDTH in   2          00 Small(8), 01 Medium(16), 10 Large(32), 11 treated as Large
//  out_valid      out  1          DATA_OUT/NUM_OF_ERRORS valid
//  out_ready      in   1          sink accepts
//  DATA_OUT       out  AMBA_WORD  corrected data, LSB-aligned, zero-extended (4/11/26 bits)
//  NUM_OF_ERRORS  out  2          0 clean, 1 corrected, 2 uncorrectable, 3 never driven
//  clr_cnt        in   1          synchronous clear of both counters
//  CORR_CNT       out  CNT_W      beats delivered with NUM_OF_ERRORS==1, saturating
//  UNCORR_CNT     out  CNT_W      beats delivered with NUM_OF_ERRORS==2, saturating
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all stage valids, out_valid, DATA_OUT, NUM_OF_ERRORS,
//    CORR_CNT, UNCORR_CNT := 0. Reset mid-operation drops every in-flight beat.
//  - Single pipeline advance: adv = !out_valid | out_ready; in_ready = adv. Every stage
//    register loads only when adv; bubbles propagate as valid=0. Accept = in_valid & in_ready.
//  - Latency exactly 3 cycles accept->out_valid under no stall; throughput 1 beat/cycle.
//  - S0: capture DATA_IN and size; left-shift codeword to MSB-aligned r[31:0] (shift 24/16/0).
//  - S1: p' = Encoder parity of r data bits (4/5/6 bits for S/M/L, same equations);
//    S = p' ^ received parity bits (r[27:24] / r[20:16] / r[5:0]).
//  - S2: S==0 -> err 0, no change. S equals column j of the size's H table -> flip r[j],
//    err 1. Otherwise -> err 2, data passed uncorrected. Extract data: S r[31:28], M r[31:21],
//    L r[31:6]; zero-extend into DATA_OUT.
//  - Size travels with each beat; width may change every beat with no flush.
//  - Output holds DATA_OUT/NUM_OF_ERRORS stable while out_valid & !out_ready.
//  - Counters increment on out_valid & out_ready per NUM_OF_ERRORS; saturate at all-ones;
//    clr_cnt same cycle as increment -> counter becomes 0.
// STRUCTURE
//  - Package ecc_pkg: width codes (CW_SMALL/MEDIUM/LARGE), per-size N/K/parity-count
//    constants, H column tables (syndrome of a single flip at each aligned bit position),
//    shared by Encoder rework and this block.
//  - One sub-module: ecc_parity_gen (combinational, MSB-aligned data + size -> 6-bit
//    parity, unused bits 0); instantiated in S1.
// TESTING
//  - Small 0x000000B1 -> DATA_OUT 0x0000000B, err 0, 3 cycles after accept.
//  - Small 0x00000031 (bit7 flipped) -> DATA_OUT 0xB, err 1; CORR_CNT +1.
//  - Small 0x00000071 (bits 7,6 flipped, S=1001) -> err 2; UNCORR_CNT +1; DATA_OUT 0x7.
//  - Large 0x00000001 (all-zero codeword, parity bit0 flipped) -> DATA_OUT 0, err 1.
//  - Back-to-back S/M/L beats, out_ready low 5 cycles -> in_ready low, no loss/dup, order kept.
//  - rst low mid-stream with 3 beats in flight -> no output; counters 0; clr_cnt with
//    an err-1 beat accepted -> CORR_CNT 0; counter at 0xFFFF stays 0xFFFF.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: width codes, per-size geometry and H column tables.
// Tables are indexed by MSB-aligned bit position, matching the Encoder's Enc_Out layout.
package ecc_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        CW_SMALL  = 2'b00,
        CW_MEDIUM = 2'b01,
        CW_LARGE  = 2'b10
    } cw_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CORR   = 2'd1,
        ERR_UNCORR = 2'd2
    } err_e;

    localparam int unsigned N_S = 8;
    localparam int unsigned K_S = 4;
    localparam int unsigned P_S = 4;
    localparam int unsigned N_M = 16;
    localparam int unsigned K_M = 11;
    localparam int unsigned P_M = 5;
    localparam int unsigned N_L = 32;
    localparam int unsigned K_L = 26;
    localparam int unsigned P_L = 6;

    // Data-bit columns, element [i] belongs to data bit i (LSB of the data field).
    // All columns have odd weight, so any double error gives an even, non-column syndrome.
    localparam logic [3:0][5:0]  H_S = {6'h07, 6'h0E, 6'h0B, 6'h0D};
    localparam logic [10:0][5:0] H_M = {6'h1F, 6'h1C, 6'h1A, 6'h19, 6'h16, 6'h15,
                                        6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};
    localparam logic [25:0][5:0] H_L = {6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F,
                                        6'h38, 6'h34, 6'h32, 6'h31, 6'h2C, 6'h2A,
                                        6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
                                        6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D,
                                        6'h0B, 6'h07};

    // Syndrome produced by a single flip at aligned position pos; 0 where the size has no bit.
    function automatic logic [5:0] h_col(input cw_e cw, input int unsigned pos);
        int unsigned base;
        int unsigned np;
        logic [5:0]  col;
        col = '0;
        case (cw)
            CW_SMALL:  begin base = WORD_W - N_S; np = P_S; end
            CW_MEDIUM: begin base = WORD_W - N_M; np = P_M; end
            default:   begin base = WORD_W - N_L; np = P_L; end
        endcase
        if (pos >= base + np) begin
            case (cw)
                CW_SMALL:  col = H_S[pos - base - np];
                CW_MEDIUM: col = H_M[pos - base - np];
                default:   col = H_L[pos - base - np];
            endcase
        end else if (pos >= base) begin
            col = 6'(1) << (pos - base);
        end
        return col;
    endfunction

    function automatic logic is_data_bit(input cw_e cw, input int unsigned pos);
        int unsigned k;
        case (cw)
            CW_SMALL:  k = K_S;
            CW_MEDIUM: k = K_M;
            default:   k = K_L;
        endcase
        return pos >= WORD_W - k;
    endfunction

endpackage

// File: rtl/ecc_decoder_pipe_parity_gen.sv
// Combinational Encoder parity over the data bits of an MSB-aligned codeword.
module ecc_parity_gen
    import ecc_pkg::*;
(
    input  logic [31:0] i_data,
    input  cw_e         i_cw,
    output logic [5:0]  o_parity
);

    always_comb begin
        o_parity = '0;
        for (int unsigned j = 0; j < WORD_W; j++) begin
            if (i_data[j] && is_data_bit(i_cw, j)) begin
                o_parity = o_parity ^ h_col(i_cw, j);
            end
        end
    end

endmodule

// File: rtl/ecc_decoder_pipe.sv
// 3-stage SECDED decoder: align, syndrome, correct/extract; single stall-wide advance.
module ecc_decoder_pipe
    import ecc_pkg::*;
#(
    parameter int unsigned AMBA_WORD = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [1:0]           CODEWORD_WIDTH,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] DATA_OUT,
    output logic [1:0]           NUM_OF_ERRORS,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     CORR_CNT,
    output logic [CNT_W-1:0]     UNCORR_CNT
);

    logic        w_adv;
    logic        w_fire;
    cw_e         w_cw_in;
    logic [31:0] w_aligned;
    logic [5:0]  w_parity;
    logic [5:0]  w_recv_par;
    logic [31:0] w_flip;
    logic [31:0] w_fixed;
    err_e        w_err;
    logic [31:0] w_data_out;

    logic        r_s0_valid;
    logic [31:0] r_s0_word;
    cw_e         r_s0_cw;
    logic        r_s1_valid;
    logic [31:0] r_s1_word;
    cw_e         r_s1_cw;
    logic [5:0]  r_s1_syn;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_fire   = out_valid && out_ready;

    always_comb begin
        w_cw_in   = CW_LARGE;
        w_aligned = DATA_IN;
        case (CODEWORD_WIDTH)
            2'b00: begin w_cw_in = CW_SMALL;  w_aligned = {DATA_IN[7:0], 24'b0};  end
            2'b01: begin w_cw_in = CW_MEDIUM; w_aligned = {DATA_IN[15:0], 16'b0}; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s0_valid <= 1'b0;
            r_s0_word  <= '0;
            r_s0_cw    <= CW_SMALL;
        end else if (w_adv) begin
            r_s0_valid <= in_valid;
            r_s0_word  <= w_aligned;
            r_s0_cw    <= w_cw_in;
        end
    end

    ecc_parity_gen u_parity_gen (
        .i_data   (r_s0_word),
        .i_cw     (r_s0_cw),
        .o_parity (w_parity)
    );

    always_comb begin
        case (r_s0_cw)
            CW_SMALL:  w_recv_par = {2'b0, r_s0_word[27:24]};
            CW_MEDIUM: w_recv_par = {1'b0, r_s0_word[20:16]};
            default:   w_recv_par = r_s0_word[5:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_s1_cw    <= CW_SMALL;
            r_s1_syn   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= r_s0_valid;
            r_s1_word  <= r_s0_word;
            r_s1_cw    <= r_s0_cw;
            r_s1_syn   <= w_parity ^ w_recv_par;
        end
    end

    // Positions outside the current size have a zero column and can never match a nonzero syndrome.
    always_comb begin
        w_flip = '0;
        for (int unsigned j = 0; j < WORD_W; j++) begin
            if (r_s1_syn != '0 && h_col(r_s1_cw, j) == r_s1_syn) begin
                w_flip[j] = 1'b1;
            end
        end
        w_fixed = r_s1_word ^ w_flip;
        if (r_s1_syn == '0) begin
            w_err = ERR_NONE;
        end else if (w_flip != '0) begin
            w_err = ERR_CORR;
        end else begin
            w_err = ERR_UNCORR;
        end
        case (r_s1_cw)
            CW_SMALL:  w_data_out = {28'b0, w_fixed[31:28]};
            CW_MEDIUM: w_data_out = {21'b0, w_fixed[31:21]};
            default:   w_data_out = {6'b0, w_fixed[31:6]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            DATA_OUT      <= '0;
            NUM_OF_ERRORS <= '0;
        end else if (w_adv) begin
            out_valid     <= r_s1_valid;
            DATA_OUT      <= w_data_out;
            NUM_OF_ERRORS <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_cnt) begin
            CORR_CNT   <= '0;
            UNCORR_CNT <= '0;
        end else if (w_fire) begin
            if (NUM_OF_ERRORS == ERR_CORR && CORR_CNT != '1) begin
                CORR_CNT <= CORR_CNT + CNT_W'(1);
            end
            if (NUM_OF_ERRORS == ERR_UNCORR && UNCORR_CNT != '1) begin
                UNCORR_CNT <= UNCORR_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ecc_decoder_pipe.sv
// Scoreboard bench for ecc_decoder_pipe: brute-force SECDED reference, per-cycle counter model.
module tb_ecc_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] DATA_IN;
    logic [1:0]  CODEWORD_WIDTH;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] DATA_OUT;
    logic [1:0]  NUM_OF_ERRORS;
    logic        clr_cnt;
    logic [15:0] CORR_CNT;
    logic [15:0] UNCORR_CNT;

    always #5 clk = ~clk;

    ecc_decoder_pipe #(.AMBA_WORD(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .DATA_IN        (DATA_IN),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .DATA_OUT       (DATA_OUT),
        .NUM_OF_ERRORS  (NUM_OF_ERRORS),
        .clr_cnt        (clr_cnt),
        .CORR_CNT       (CORR_CNT),
        .UNCORR_CNT     (UNCORR_CNT)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int unsigned acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    bit          acc_flag = 1'b0;
    bit          lat_mode = 1'b0;
    bit          prev_stall = 1'b0;
    bit          ovr_en   = 1'b0;
    logic [31:0] ovr_data;
    logic [1:0]  ovr_err;
    logic [31:0] prev_data;
    logic [1:0]  prev_err;
    logic [15:0] exp_corr = '0;
    logic [15:0] exp_unc  = '0;
    logic [33:0] mon_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned n_bits(input logic [1:0] w);
        case (w)
            2'b00:   return 8;
            2'b01:   return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned p_bits(input logic [1:0] w);
        case (w)
            2'b00:   return 4;
            2'b01:   return 5;
            default: return 6;
        endcase
    endfunction

    // Hsiao columns: Small is a fixed table; Medium/Large list weight-3 then weight-5 vectors ascending.
    function automatic logic [5:0] dcol(input logic [1:0] w, input int unsigned i);
        int unsigned n;
        int unsigned p;
        if (w == 2'b00) begin
            case (i)
                0:       return 6'h0D;
                1:       return 6'h0B;
                2:       return 6'h0E;
                default: return 6'h07;
            endcase
        end
        n = 0;
        p = p_bits(w);
        for (int unsigned wt = 3; wt <= 5; wt += 2) begin
            for (int unsigned v = 1; v < (32'd1 << p); v++) begin
                if ($countones(v) == wt) begin
                    if (n == i) return 6'(v);
                    n++;
                end
            end
        end
        return 6'h0;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] w);
        int unsigned p;
        int unsigned k;
        logic [5:0]  par;
        p   = p_bits(w);
        k   = n_bits(w) - p;
        par = '0;
        for (int unsigned i = 0; i < k; i++) begin
            if (d[i]) par = par ^ dcol(w, i);
        end
        return ((d & ((32'h1 << k) - 32'h1)) << p) | 32'(par);
    endfunction

    // Returns {err, data}: a codeword is correctable iff exactly one bit flip makes it valid.
    function automatic logic [33:0] ref_decode(input logic [31:0] cw, input logic [1:0] w);
        int unsigned n;
        int unsigned p;
        logic [31:0] c;
        logic [31:0] c2;
        n = n_bits(w);
        p = p_bits(w);
        c = (n == 32) ? cw : (cw & ((32'h1 << n) - 32'h1));
        if (encode(c >> p, w) == c) return {2'd0, c >> p};
        for (int unsigned j = 0; j < n; j++) begin
            c2 = c ^ (32'h1 << j);
            if (encode(c2 >> p, w) == c2) return {2'd1, c2 >> p};
        end
        return {2'd2, c >> p};
    endfunction

    function automatic logic [31:0] rand_cw(input logic [1:0] w, input int unsigned nflip);
        int unsigned n;
        int unsigned j1;
        int unsigned j2;
        logic [31:0] c;
        n  = n_bits(w);
        c  = encode($urandom, w);
        j1 = $urandom_range(0, n - 1);
        if (nflip >= 1) c[j1] = ~c[j1];
        if (nflip == 2) begin
            j2 = (j1 + $urandom_range(1, n - 1)) % n;
            c[j2] = ~c[j2];
        end
        if (n < 32) c = c | ($urandom << n);
        return c;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            sb.delete();
            exp_corr   = '0;
            exp_unc    = '0;
            acc_flag   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check_eq("corr_cnt", CORR_CNT, exp_corr);
            check_eq("uncorr_cnt", UNCORR_CNT, exp_unc);
            if (prev_stall) begin
                check_eq("hold_data", DATA_OUT, prev_data);
                check_eq("hold_err", NUM_OF_ERRORS, prev_err);
            end
            if (out_valid && !out_ready) check_eq("in_ready_stall", in_ready, 1'b0);
            else                         check_eq("in_ready_free", in_ready, 1'b1);
            if (out_valid && sb.size() == 0) begin
                check_eq("spurious_valid", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                mon_e = sb.pop_front();
                check_eq("data_out", DATA_OUT, mon_e.data);
                check_eq("num_errors", NUM_OF_ERRORS, mon_e.err);
                if (mon_e.lat) check_eq("latency", cyc - mon_e.acc, 3);
                if (mon_e.err == 2'd1 && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
                if (mon_e.err == 2'd2 && exp_unc != 16'hFFFF) exp_unc = exp_unc + 16'd1;
            end
            if (clr_cnt) begin
                exp_corr = '0;
                exp_unc  = '0;
            end
            acc_flag = in_valid && in_ready;
            if (acc_flag) begin
                mon_m = ref_decode(DATA_IN, CODEWORD_WIDTH);
                if (ovr_en) sb.push_back('{ovr_data, ovr_err, cyc, lat_mode});
                else        sb.push_back('{mon_m[31:0], mon_m[33:32], cyc, lat_mode});
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = DATA_OUT;
            prev_err   = NUM_OF_ERRORS;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] w);
        in_valid       = 1'b1;
        DATA_IN        = d;
        CODEWORD_WIDTH = w;
        for (int t = 0; t < 500; t++) begin
            tick();
            if (acc_flag) return;
        end
        check_eq("accept_timeout", {31'b0, acc_flag}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_known(input logic [31:0] d, input logic [1:0] w,
                              input logic [31:0] exp_d, input logic [1:0] exp_e);
        ovr_en   = 1'b1;
        ovr_data = exp_d;
        ovr_err  = exp_e;
        send(d, w);
        ovr_en   = 1'b0;
        idle(6);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b0;
        DATA_IN        = '0;
        CODEWORD_WIDTH = '0;
        out_ready      = 1'b1;
        clr_cnt        = 1'b0;
        repeat (3) tick();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_data_out", DATA_OUT, 32'h0);
        check_eq("rst_num_err", NUM_OF_ERRORS, 2'd0);
        check_eq("rst_corr_cnt", CORR_CNT, 16'h0);
        check_eq("rst_uncorr_cnt", UNCORR_CNT, 16'h0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        tick();

        lat_mode = 1'b1;
        send_known(32'h0000_00B1, 2'b00, 32'hB, 2'd0);
        send_known(32'h0000_0031, 2'b00, 32'hB, 2'd1);
        send_known(32'h0000_0071, 2'b00, 32'h7, 2'd2);
        send_known(32'h0000_0001, 2'b10, 32'h0, 2'd1);
        send_known(32'hFFFF_FF31, 2'b00, 32'hB, 2'd1);
        lat_mode = 1'b0;

        fork
            begin
                for (int i = 0; i < 12; i++) send(rand_cw(2'(i % 3), (i % 4 == 1) ? 1 : 0), 2'(i % 3));
                in_valid = 1'b0;
            end
            begin
                repeat (4) tick();
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
            end
        join
        drain();

        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(rand_cw(2'($urandom_range(0, 3)), $urandom_range(0, 2)), 2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 4) == 0) idle(1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (260) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(32'h0000_0031, 2'b00);
        in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid) break;
            tick();
        end
        check_eq("clr_wait_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        tick();
        clr_cnt = 1'b0;
        tick();
        check_eq("clr_with_inc", CORR_CNT, 16'h0);

        repeat (3) send(rand_cw(2'b01, 1), 2'b01);
        idle(3);
        out_ready = 1'b0;
        repeat (3) send(rand_cw(2'b10, 2), 2'b10);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        idle(6);
        check_eq("rst_flush_valid", out_valid, 1'b0);
        check_eq("rst_flush_corr", CORR_CNT, 16'h0);
        check_eq("rst_flush_uncorr", UNCORR_CNT, 16'h0);

        for (int i = 0; i < 65540; i++) send(32'h0000_0031, 2'b00);
        drain();
        idle(2);
        check_eq("corr_sat", CORR_CNT, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
